// File: rtl/jstk_adjust_ctrl.sv
// Polling sequencer and direction decoder between the PmodJSTK SPI interface
// and the stopwatch counter: polls, decodes X/Y/buttons, emits adjust pulses.
module jstk_adjust_ctrl #(
    parameter int unsigned POLL_DIV     = 20_000_000,
    parameter int unsigned TIMEOUT      = 1_000_000,
    parameter int unsigned DEAD_LO      = 384,
    parameter int unsigned DEAD_HI      = 640,
    parameter int unsigned REPEAT_POLLS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adj_en,
    input  logic        poll_done,
    input  logic [39:0] jstk_data,
    output logic        poll_req,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [2:0]  btn,
    output logic        field_sel,
    output logic        inc_pulse,
    output logic        dec_pulse,
    output logic        link_err
);

    localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RW = (REPEAT_POLLS > 1) ? $clog2(REPEAT_POLLS) : 1;

    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_POLLS - 1);
    localparam logic [9:0]    DEAD_LO_V = 10'(DEAD_LO);
    localparam logic [9:0]    DEAD_HI_V = 10'(DEAD_HI);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LATCH,
        S_DECIDE
    } state_t;

    typedef enum logic [1:0] {
        DIR_NEUTRAL,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    state_t        state_q, state_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    dir_t          last_dir_q, last_dir_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic [2:0]    btn_q, btn_d;
    logic          field_sel_q, field_sel_d;
    logic          link_err_q, link_err_d;

    logic tick;
    logic fire;
    dir_t dir_y;

    logic unused_data_bits;
    assign unused_data_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:3]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            poll_cnt_q  <= '0;
            to_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            last_dir_q  <= DIR_NEUTRAL;
            pos_x_q     <= 10'd512;
            pos_y_q     <= 10'd512;
            btn_q       <= '0;
            field_sel_q <= 1'b0;
            link_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            last_dir_q  <= last_dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            btn_q       <= btn_d;
            field_sel_q <= field_sel_d;
            link_err_q  <= link_err_d;
        end
    end

    always_comb begin
        tick       = (poll_cnt_q == POLL_LAST);
        poll_cnt_d = tick ? '0 : poll_cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tick) state_d = S_REQ;
            S_REQ:    state_d = S_WAIT;
            S_WAIT: begin
                if (poll_done)                state_d = S_LATCH;
                else if (to_cnt_q == TO_LAST) state_d = S_IDLE;
            end
            S_LATCH:  state_d = S_DECIDE;
            S_DECIDE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (pos_y_q > DEAD_HI_V)      dir_y = DIR_UP;
        else if (pos_y_q < DEAD_LO_V) dir_y = DIR_DOWN;
        else                          dir_y = DIR_NEUTRAL;
    end

    // Positions are captured on the WAIT->LATCH edge so they are valid during
    // LATCH; field_sel follows in LATCH, pulses are driven during DECIDE.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        last_dir_d  = last_dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        btn_d       = btn_q;
        field_sel_d = field_sel_q;
        link_err_d  = link_err_q;
        fire        = 1'b0;
        case (state_q)
            S_REQ: to_cnt_d = '0;
            S_WAIT: begin
                if (poll_done) begin
                    pos_x_d    = {jstk_data[25:24], jstk_data[39:32]};
                    pos_y_d    = {jstk_data[9:8], jstk_data[23:16]};
                    btn_d      = jstk_data[2:0];
                    link_err_d = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    link_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (pos_x_q < DEAD_LO_V)      field_sel_d = 1'b1;
                else if (pos_x_q > DEAD_HI_V) field_sel_d = 1'b0;
            end
            S_DECIDE: begin
                if (!adj_en) begin
                    rep_cnt_d  = '0;
                    last_dir_d = DIR_NEUTRAL;
                end else begin
                    last_dir_d = dir_y;
                    if (dir_y == DIR_NEUTRAL) begin
                        rep_cnt_d = '0;
                    end else if (dir_y != last_dir_q) begin
                        fire      = 1'b1;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == REP_LAST) begin
                        fire      = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        poll_req  = (state_q == S_REQ);
        inc_pulse = fire && (dir_y == DIR_UP);
        dec_pulse = fire && (dir_y == DIR_DOWN);
        pos_x     = pos_x_q;
        pos_y     = pos_y_q;
        btn       = btn_q;
        field_sel = field_sel_q;
        link_err  = link_err_q;
    end

endmodule

// File: tb/tb_jstk_adjust_ctrl.sv
// Directed self-checking bench for jstk_adjust_ctrl with short poll/timeout
// periods; poll_done is returned 3 cycles after poll_req.
module tb_jstk_adjust_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        adj_en = 1'b0;
    logic        poll_done = 1'b0;
    logic [39:0] jstk_data = '0;
    logic        poll_req;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [2:0]  btn;
    logic        field_sel;
    logic        inc_pulse;
    logic        dec_pulse;
    logic        link_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        bit         got;
        int         rc;
        logic       req1;
        logic [9:0] px;
        logic [9:0] py;
        logic [2:0] b;
        logic       fs;
        logic       lerr;
        logic       inc1, inc2, inc3;
        logic       dec1, dec2, dec3;
    } obs_t;

    jstk_adjust_ctrl #(
        .POLL_DIV(16),
        .TIMEOUT(8),
        .DEAD_LO(384),
        .DEAD_HI(640),
        .REPEAT_POLLS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adj_en(adj_en),
        .poll_done(poll_done),
        .jstk_data(jstk_data),
        .poll_req(poll_req),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .btn(btn),
        .field_sel(field_sel),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .link_err(link_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] mk(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        logic [39:0] d;
        d = '0;
        d[39:32] = x[7:0];
        d[25:24] = x[9:8];
        d[23:16] = y[7:0];
        d[9:8]   = y[9:8];
        d[2:0]   = b;
        return d;
    endfunction

    // Waits for poll_req, returns poll_done in cycle R+3 and samples outputs
    // at R+1 .. R+6 (N = R+3).
    task automatic run_poll(input logic [39:0] d, output obs_t o);
        o = '{default: '0};
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (poll_req === 1'b1) begin
                o.got = 1'b1;
                o.rc  = cyc;
                break;
            end
        end
        if (!o.got) return;
        jstk_data = d;
        @(posedge clk); #1;
        o.req1 = poll_req;
        @(posedge clk); #1;
        @(posedge clk); #1;
        poll_done = 1'b1;
        @(posedge clk); #1;
        poll_done = 1'b0;
        o.px = pos_x; o.py = pos_y; o.b = btn;
        o.inc1 = inc_pulse; o.dec1 = dec_pulse;
        @(posedge clk); #1;
        o.inc2 = inc_pulse; o.dec2 = dec_pulse; o.fs = field_sel;
        @(posedge clk); #1;
        o.inc3 = inc_pulse; o.dec3 = dec_pulse; o.lerr = link_err;
    endtask

    task automatic test_reset;
        obs_t o;
        int   rel;
        int   prev;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({pos_x, pos_y} !== {10'd512, 10'd512}) begin
            n_fail++; $display("FAIL reset_pos: got x=%0d y=%0d, expected 512/512", pos_x, pos_y);
        end
        n_chk++;
        if ({poll_req, inc_pulse, dec_pulse, link_err, field_sel, btn} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got req=%b inc=%b dec=%b lerr=%b fs=%b btn=%0d, expected all 0",
                     poll_req, inc_pulse, dec_pulse, link_err, field_sel, btn);
        end
        rst = 1'b1;
        rel = cyc;
        run_poll(mk(10'd512, 10'd512, 3'd0), o);
        n_chk++;
        if (!o.got || (o.rc - rel) != 16) begin
            n_fail++; $display("FAIL first_poll_req: got=%0d at %0d cycles, expected at 16", o.got, o.rc - rel);
        end
        n_chk++;
        if (o.req1 !== 1'b0) begin
            n_fail++; $display("FAIL poll_req_width: got %b in cycle after req, expected 0", o.req1);
        end
        n_chk++;
        if ({o.inc2, o.dec2} !== 2'b00) begin
            n_fail++; $display("FAIL reset_no_pulse: got inc=%b dec=%b, expected 0 0", o.inc2, o.dec2);
        end
        prev = o.rc;
        run_poll(mk(10'd512, 10'd512, 3'd0), o);
        n_chk++;
        if (!o.got || (o.rc - prev) != 16) begin
            n_fail++; $display("FAIL poll_period: got=%0d period %0d, expected 16", o.got, o.rc - prev);
        end
    endtask

    task automatic test_decode;
        obs_t o;
        adj_en = 1'b0;
        run_poll(mk(10'h3FF, 10'h005, 3'b101), o);
        n_chk++;
        if (o.px !== 10'd1023 || o.py !== 10'd5 || o.b !== 3'd5) begin
            n_fail++; $display("FAIL decode_fields: got x=%0d y=%0d btn=%0d, expected 1023 5 5", o.px, o.py, o.b);
        end
        n_chk++;
        if (o.fs !== 1'b0) begin
            n_fail++; $display("FAIL decode_field_sel: got %b, expected 0", o.fs);
        end
        n_chk++;
        if ({o.inc2, o.dec2} !== 2'b00) begin
            n_fail++; $display("FAIL decode_no_pulse: got inc=%b dec=%b, expected 0 0", o.inc2, o.dec2);
        end
    endtask

    task automatic test_auto_repeat;
        obs_t o;
        logic exp_inc;
        adj_en = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            run_poll(mk(10'd512, 10'd1000, 3'd0), o);
            exp_inc = (p == 1 || p == 4 || p == 7);
            n_chk++;
            if (o.inc2 !== exp_inc || o.dec2 !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat_poll%0d: got inc=%b dec=%b, expected inc=%b dec=0", p, o.inc2, o.dec2, exp_inc);
            end
            n_chk++;
            if ({o.inc1, o.inc3, o.dec1, o.dec3} !== 4'b0) begin
                n_fail++;
                $display("FAIL repeat_width%0d: got inc@N+1=%b inc@N+3=%b dec=%b%b, expected 0",
                         p, o.inc1, o.inc3, o.dec1, o.dec3);
            end
        end
    endtask

    task automatic test_reversal;
        obs_t o;
        logic [9:0] ys   [10] = '{10'd512, 10'd1000, 10'd10, 10'd512, 10'd10, 10'd10,
                                  10'd640, 10'd641, 10'd384, 10'd383};
        logic       ens  [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        logic       einc [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        logic       edec [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            adj_en = ens[i];
            run_poll(mk(10'd512, ys[i], 3'd0), o);
            n_chk++;
            if (o.inc2 !== einc[i] || o.dec2 !== edec[i]) begin
                n_fail++;
                $display("FAIL reversal_step%0d (y=%0d en=%b): got inc=%b dec=%b, expected inc=%b dec=%b",
                         i, ys[i], ens[i], o.inc2, o.dec2, einc[i], edec[i]);
            end
        end
    endtask

    task automatic test_field_select;
        obs_t o;
        logic [9:0] xs  [7] = '{10'd100, 10'd512, 10'd900, 10'd383, 10'd384, 10'd640, 10'd641};
        logic       efs [7] = '{1, 1, 0, 1, 1, 1, 0};
        for (int e = 0; e < 2; e++) begin
            adj_en = (e == 0);
            for (int i = 0; i < 7; i++) begin
                run_poll(mk(xs[i], 10'd512, 3'd0), o);
                n_chk++;
                if (o.fs !== efs[i]) begin
                    n_fail++;
                    $display("FAIL field_sel_x%0d_en%b: got %b, expected %b", xs[i], adj_en, o.fs, efs[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        bit   got;
        int   r;
        logic lerr_early;
        adj_en = 1'b1;
        run_poll(mk(10'd512, 10'd1000, 3'd0), o);
        n_chk++;
        if (o.inc2 !== 1'b1) begin
            n_fail++; $display("FAIL timeout_pre_inc: got %b, expected 1", o.inc2);
        end
        got = 1'b0;
        r = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (poll_req === 1'b1) begin got = 1'b1; r = cyc; break; end
        end
        n_chk++;
        if (!got) begin
            n_fail++; $display("FAIL timeout_req: got no poll_req, expected one within 40 cycles");
        end
        jstk_data = mk(10'd100, 10'd100, 3'd7);
        repeat (8) begin @(posedge clk); #1; end
        lerr_early = link_err;
        @(posedge clk); #1;
        n_chk++;
        if (lerr_early !== 1'b0 || link_err !== 1'b1 || (cyc - r) != 9) begin
            n_fail++;
            $display("FAIL timeout_link_err: got %b at +8 and %b at +%0d, expected 0 at +8 and 1 at +9",
                     lerr_early, link_err, cyc - r);
        end
        n_chk++;
        if (pos_x !== 10'd512 || pos_y !== 10'd1000) begin
            n_fail++; $display("FAIL timeout_hold_pos: got x=%0d y=%0d, expected 512 1000", pos_x, pos_y);
        end
        run_poll(mk(10'd512, 10'd1000, 3'd0), o);
        n_chk++;
        if (o.lerr !== 1'b0) begin
            n_fail++; $display("FAIL timeout_recover: got link_err=%b, expected 0", o.lerr);
        end
        n_chk++;
        if (o.inc2 !== 1'b0) begin
            n_fail++; $display("FAIL timeout_keeps_dir: got inc=%b, expected 0", o.inc2);
        end
    endtask

    task automatic test_reset_in_wait;
        obs_t o;
        bit   got;
        logic any_pulse;
        adj_en = 1'b1;
        run_poll(mk(10'd100, 10'd512, 3'd3), o);
        n_chk++;
        if (o.px !== 10'd100 || o.fs !== 1'b1) begin
            n_fail++; $display("FAIL rstwait_setup: got x=%0d fs=%b, expected 100 1", o.px, o.fs);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (poll_req === 1'b1) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_chk++;
        if (!got || pos_x !== 10'd512 || pos_y !== 10'd512 || btn !== 3'd0 || field_sel !== 1'b0
            || link_err !== 1'b0 || poll_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_async: got req_seen=%b x=%0d y=%0d btn=%0d fs=%b lerr=%b req=%b, expected 1 512 512 0 0 0 0",
                     got, pos_x, pos_y, btn, field_sel, link_err, poll_req);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        jstk_data = mk(10'd100, 10'd100, 3'd7);
        poll_done = 1'b1;
        any_pulse = 1'b0;
        @(posedge clk); #1;
        poll_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            any_pulse = any_pulse | inc_pulse | dec_pulse;
        end
        n_chk++;
        if (pos_x !== 10'd512 || pos_y !== 10'd512 || btn !== 3'd0 || field_sel !== 1'b0 || any_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_late_done: got x=%0d y=%0d btn=%0d fs=%b pulse=%b, expected 512 512 0 0 0",
                     pos_x, pos_y, btn, field_sel, any_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_auto_repeat();
        test_reversal();
        test_field_select();
        test_timeout();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
